// File: rtl/mnist_sample_packer.sv
// mnist_sample_packer
// Converts one MNIST sample, arriving as a byte stream, into the 794-bit word
// used by the ten one-vs-rest learners. The stream is one label byte followed
// by 784 grey-level pixel bytes. Each pixel is binarized against a threshold
// that is captured on the label beat.
//
// Ports
//   clk           : sole clock, rising edge
//   rst_n         : asynchronous, active-low reset
//   s_valid       : input beat valid
//   s_ready       : beat accepted when s_valid & s_ready (equals !pause)
//   s_data        : label byte (first beat of a frame) or pixel byte
//   bin_threshold : binarization threshold, captured on the label beat
//   pause         : holds s_ready low while high
//   image_data    : {pixel bits [793:10], one-hot label [9:0]}, held between frames
//   img_valid     : one-cycle strobe, image_data is fresh this cycle
//   frame_err     : one-cycle strobe, a frame with label >= N_CLASS was dropped
//   sample_cnt    : number of emitted frames, wraps 0xFFFF -> 0
module mnist_sample_packer #(
    parameter int N_PIX   = 784,
    parameter int N_CLASS = 10,
    parameter int PIX_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [PIX_W-1:0]         s_data,
    input  logic [PIX_W-1:0]         bin_threshold,
    input  logic                     pause,
    output logic [N_PIX+N_CLASS-1:0] image_data,
    output logic                     img_valid,
    output logic                     frame_err,
    output logic [15:0]              sample_cnt
);

    localparam int               CNT_W    = 10;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_PIX - 1);

    typedef enum logic [1:0] {
        S_LABEL = 2'd0,
        S_PIX   = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [CNT_W-1:0]         r_pix_cnt;
    logic [CNT_W-1:0]         w_pix_cnt_nxt;
    logic [N_PIX-1:0]         r_shadow;
    logic [N_CLASS-1:0]       r_label;
    logic [PIX_W-1:0]         r_thr;
    logic [N_PIX+N_CLASS-1:0] r_image;
    logic                     r_img_valid;
    logic                     r_frame_err;
    logic [15:0]              r_sample_cnt;

    logic w_accept;
    logic w_last;
    logic w_label_ok;
    logic w_pix_bit;
    logic w_start_ok;
    logic w_pix_wr;
    logic w_emit;
    logic w_drop_done;

    function automatic logic [N_CLASS-1:0] onehot(input logic [PIX_W-1:0] idx);
        logic [N_CLASS-1:0] v;
        v = '0;
        for (int i = 0; i < N_CLASS; i++) begin
            if (idx == PIX_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign s_ready    = !pause;
    assign w_accept   = s_valid && !pause;
    assign w_last     = (r_pix_cnt == LAST_PIX);
    assign w_label_ok = (s_data < PIX_W'(N_CLASS));
    // Equal-to-threshold maps to 1, so a zero threshold sets every pixel bit.
    assign w_pix_bit  = (s_data >= r_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LABEL;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_pix_cnt_nxt = r_pix_cnt;
        w_start_ok    = 1'b0;
        w_pix_wr      = 1'b0;
        w_emit        = 1'b0;
        w_drop_done   = 1'b0;
        case (r_state)
            S_LABEL: begin
                if (w_accept) begin
                    w_pix_cnt_nxt = '0;
                    if (w_label_ok) begin
                        w_start_ok   = 1'b1;
                        w_next_state = S_PIX;
                    end else begin
                        w_next_state = S_DROP;
                    end
                end
            end
            S_PIX: begin
                if (w_accept) begin
                    w_pix_wr = 1'b1;
                    if (w_last) begin
                        w_emit        = 1'b1;
                        w_pix_cnt_nxt = '0;
                        w_next_state  = S_LABEL;
                    end else begin
                        w_pix_cnt_nxt = r_pix_cnt + 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_drop_done   = 1'b1;
                        w_pix_cnt_nxt = '0;
                        w_next_state  = S_LABEL;
                    end else begin
                        w_pix_cnt_nxt = r_pix_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_next_state  = S_LABEL;
                w_pix_cnt_nxt = '0;
            end
        endcase
    end

    // Frame context: pixel counter, label and threshold captured at the label beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt <= '0;
            r_label   <= '0;
            r_thr     <= '0;
        end else begin
            r_pix_cnt <= w_pix_cnt_nxt;
            if (w_start_ok) begin
                r_label <= onehot(s_data);
                r_thr   <= bin_threshold;
            end
        end
    end

    // Shadow assembly is kept apart from image_data so the next frame can be
    // built while the previous word is still presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (w_pix_wr) begin
            r_shadow[r_pix_cnt] <= w_pix_bit;
        end
    end

    // The last pixel is merged straight from the input because its shadow bit
    // is written on the same edge that loads image_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_image      <= '0;
            r_img_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            r_img_valid <= w_emit;
            r_frame_err <= w_drop_done;
            if (w_emit) begin
                r_image      <= {w_pix_bit, r_shadow[N_PIX-2:0], r_label};
                r_sample_cnt <= r_sample_cnt + 16'd1;
            end
        end
    end

    assign image_data = r_image;
    assign img_valid  = r_img_valid;
    assign frame_err  = r_frame_err;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_mnist_sample_packer.sv
// Testbench for mnist_sample_packer.
// Directed frames are issued by the stimulus process, which pushes the
// expected response into a queue; a monitor pops and compares whenever the
// DUT strobes img_valid or frame_err.
module tb_mnist_sample_packer;

    localparam int N_PIX   = 784;
    localparam int N_CLASS = 10;
    localparam int W       = N_PIX + N_CLASS;

    logic         clk           = 1'b0;
    logic         rst_n         = 1'b0;
    logic         s_valid       = 1'b0;
    logic         pause         = 1'b0;
    logic [7:0]   s_data        = 8'h00;
    logic [7:0]   bin_threshold = 8'h00;
    logic         s_ready;
    logic [W-1:0] image_data;
    logic         img_valid;
    logic         frame_err;
    logic [15:0]  sample_cnt;

    always #5 clk = ~clk;

    mnist_sample_packer #(.N_PIX(N_PIX), .N_CLASS(N_CLASS), .PIX_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .bin_threshold (bin_threshold),
        .pause         (pause),
        .image_data    (image_data),
        .img_valid     (img_valid),
        .frame_err     (frame_err),
        .sample_cnt    (sample_cnt)
    );

    typedef struct {
        bit           err;
        logic [W-1:0] img;
        logic [15:0]  cnt;
    } exp_t;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_err    = 0;
    logic [7:0]   pix [N_PIX];
    logic [W-1:0] last_img = '0;
    logic [15:0]  exp_cnt  = 16'h0000;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [7:0] lab, input logic [7:0] thr);
        logic [W-1:0] v;
        v = '0;
        v[N_CLASS-1:0] = 10'(1) << lab;
        for (int k = 0; k < N_PIX; k++) v[N_CLASS+k] = (pix[k] >= thr);
        return v;
    endfunction

    task automatic beat(input logic [7:0] d, input bit gaps);
        if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        s_data  = d;
        s_valid = 1'b1;
        do @(posedge clk); while (!s_ready);
        #1;
        s_valid = 1'b0;
    endtask

    // Sends a label beat and npix pixels; the threshold input is scrambled
    // right after the label beat to show it is only sampled there.
    task automatic send_frame(input logic [7:0] lab, input logic [7:0] thr,
                              input int npix, input bit gaps);
        if (npix == N_PIX) begin
            if (lab < N_CLASS) begin
                exp_cnt  = exp_cnt + 16'd1;
                last_img = model(lab, thr);
                q.push_back('{1'b0, last_img, exp_cnt});
            end else begin
                q.push_back('{1'b1, last_img, exp_cnt});
            end
        end
        bin_threshold = thr;
        beat(lab, gaps);
        bin_threshold = ~thr;
        for (int k = 0; k < npix; k++) begin
            if (gaps && k == 400) begin
                s_data  = pix[k];
                s_valid = 1'b1;
                pause   = 1'b1;
                repeat (50) @(posedge clk);
                #1;
                pause = 1'b0;
            end
            beat(pix[k], gaps);
        end
    endtask

    task automatic rand_pix();
        for (int k = 0; k < N_PIX; k++) pix[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && (img_valid || frame_err)) begin
            if (img_valid && frame_err) begin
                chk("strobes_exclusive", W'({img_valid, frame_err}), W'(2'b10));
            end else if (q.size() == 0) begin
                chk("unexpected_strobe", W'({img_valid, frame_err}), W'(2'b00));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_kind", W'(frame_err), W'(e.err));
                chk("image_data", image_data, e.img);
                chk("sample_cnt", W'(sample_cnt), W'(e.cnt));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state; beats offered during reset must be ignored.
        s_valid = 1'b1;
        s_data  = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("rst_image_data", image_data, '0);
        chk("rst_img_valid", W'(img_valid), '0);
        chk("rst_frame_err", W'(frame_err), '0);
        chk("rst_sample_cnt", W'(sample_cnt), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Valid frame: label 4, threshold 0x80, alternating pixels.
        for (int k = 0; k < N_PIX; k++) pix[k] = (k % 2 == 0) ? 8'h00 : 8'hFF;
        send_frame(8'd4, 8'h80, N_PIX, 1'b0);
        settle();
        chk("t1_label", W'(image_data[9:0]), W'(10'h010));
        chk("t1_bit10", W'(image_data[10]), W'(1'b0));
        chk("t1_bit11", W'(image_data[11]), W'(1'b1));
        chk("t1_cnt", W'(sample_cnt), W'(16'd1));

        // Threshold edges.
        rand_pix();
        pix[0] = 8'h7E;
        pix[1] = 8'h7F;
        pix[2] = 8'h80;
        send_frame(8'd2, 8'h7F, N_PIX, 1'b0);
        settle();
        chk("t2_edge_bits", W'(image_data[12:10]), W'(3'b110));
        rand_pix();
        send_frame(8'd9, 8'h00, N_PIX, 1'b0);
        settle();
        chk("t2_thr0_all_ones", W'(image_data[W-1:N_CLASS]), W'({N_PIX{1'b1}}));

        // Bad label between two good frames.
        rand_pix();
        send_frame(8'd3, 8'h40, N_PIX, 1'b0);
        rand_pix();
        send_frame(8'd12, 8'h40, N_PIX, 1'b0);
        settle();
        chk("t3_held_word", image_data, last_img);
        chk("t3_held_label", W'(image_data[9:0]), W'(10'h008));
        rand_pix();
        send_frame(8'd7, 8'hA0, N_PIX, 1'b0);

        // Back-to-back frames with random gaps and a 50-cycle pause.
        for (int f = 0; f < 3; f++) begin
            rand_pix();
            send_frame(8'($urandom_range(0, 9)), 8'($urandom_range(1, 254)), N_PIX, 1'b1);
        end
        settle();
        chk("t4_queue_drained", W'(q.size()), '0);

        // Reset mid-frame at pix_cnt = 300.
        rand_pix();
        send_frame(8'd5, 8'h80, 300, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_image", image_data, '0);
        chk("t5_rst_valid", W'(img_valid), '0);
        chk("t5_rst_err", W'(frame_err), '0);
        chk("t5_rst_cnt", W'(sample_cnt), '0);
        chk("t5_ready_in_rst", W'(s_ready), W'(1'b1));
        pause = 1'b1;
        #1;
        chk("t5_ready_paused", W'(s_ready), W'(1'b0));
        pause    = 1'b0;
        exp_cnt  = 16'h0000;
        last_img = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rand_pix();
        send_frame(8'd0, 8'h55, N_PIX, 1'b0);
        settle();
        chk("t5_label0", W'(image_data[9:0]), W'(10'h001));
        chk("t5_cnt", W'(sample_cnt), W'(16'd1));

        // Counter wrap.
        force dut.r_sample_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_sample_cnt;
        exp_cnt = 16'hFFFF;
        rand_pix();
        send_frame(8'd6, 8'h90, N_PIX, 1'b0);
        settle();
        chk("t6_wrap_cnt", W'(sample_cnt), '0);

        repeat (5) @(posedge clk);
        #1;
        chk("final_queue_empty", W'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
